// File: rtl/mem_wb_stage.sv
// MEM/WB stage register and writeback select for RV32I; 1-cycle latency, stall holds the entry, flush (wins over stall) squashes it.
// Optional retire counter enabled by defining WB_INSTRET_EN.
module mem_wb_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            flush,
   input  logic            m_valid,
   input  logic            m_regwrite,
   input  logic [4:0]      m_rd,
   input  logic [1:0]      m_wbsel,
   input  logic [2:0]      m_funct3,
   input  logic [XLEN-1:0] m_alu_res,
   input  logic [XLEN-1:0] m_memdata,
   input  logic [XLEN-1:0] m_pc4,
   output logic            rf_wr,
   output logic [4:0]      rf_wadr,
   output logic [XLEN-1:0] rf_wdt,
`ifdef WB_INSTRET_EN
   output logic [CNT_W-1:0] instret,
`endif
   output logic            wb_valid
);

   typedef struct packed {
      logic            valid;
      logic            regwrite;
      logic [4:0]      rd;
      logic [1:0]      wbsel;
      logic [2:0]      funct3;
      logic [XLEN-1:0] alu_res;
      logic [XLEN-1:0] memdata;
      logic [XLEN-1:0] pc4;
   } wb_stg_t;

   wb_stg_t         r_stg;
   wb_stg_t         w_nxt;
   logic [7:0]      w_byte;
   logic [15:0]     w_half;
   logic [XLEN-1:0] w_load;

   always_comb begin
      w_nxt          = '0;
      w_nxt.valid    = m_valid;
      w_nxt.regwrite = m_regwrite;
      w_nxt.rd       = m_rd;
      w_nxt.wbsel    = m_wbsel;
      w_nxt.funct3   = m_funct3;
      w_nxt.alu_res  = m_alu_res;
      w_nxt.memdata  = m_memdata;
      w_nxt.pc4      = m_pc4;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stg <= '0;
      end else if (flush) begin
         r_stg <= '0;
      end else if (!stall) begin
         r_stg <= w_nxt;
      end
   end

   // Little-endian lane select; halfword ignores off[0] since misalignment traps upstream.
   always_comb begin
      w_byte = 8'h00;
      case (r_stg.alu_res[1:0])
         2'd0:    w_byte = r_stg.memdata[7:0];
         2'd1:    w_byte = r_stg.memdata[15:8];
         2'd2:    w_byte = r_stg.memdata[23:16];
         default: w_byte = r_stg.memdata[31:24];
      endcase
      w_half = r_stg.alu_res[1] ? r_stg.memdata[31:16] : r_stg.memdata[15:0];
   end

   always_comb begin
      w_load = r_stg.memdata;
      case (r_stg.funct3)
         3'b000:  w_load = {{(XLEN-8){w_byte[7]}}, w_byte};
         3'b100:  w_load = {{(XLEN-8){1'b0}}, w_byte};
         3'b001:  w_load = {{(XLEN-16){w_half[15]}}, w_half};
         3'b101:  w_load = {{(XLEN-16){1'b0}}, w_half};
         default: w_load = r_stg.memdata;
      endcase
   end

   always_comb begin
      rf_wdt = '0;
      case (r_stg.wbsel)
         2'b00:   rf_wdt = r_stg.alu_res;
         2'b01:   rf_wdt = w_load;
         2'b10:   rf_wdt = r_stg.pc4;
         default: rf_wdt = '0;
      endcase
   end

   assign rf_wr    = r_stg.valid & r_stg.regwrite & (r_stg.rd != 5'd0);
   assign rf_wadr  = r_stg.rd;
   assign wb_valid = r_stg.valid;

`ifdef WB_INSTRET_EN
   logic [CNT_W-1:0] r_instret;

   // A stalled entry counts only on the edge it finally leaves WB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instret <= '0;
      end else if (r_stg.valid && !stall) begin
         r_instret <= r_instret + CNT_W'(1);
      end
   end

   assign instret = r_instret;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: reset, ALU/load/PC+4 writeback, rd=0, stall/flush, optional retire counter.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        m_valid;
   logic        m_regwrite;
   logic [4:0]  m_rd;
   logic [1:0]  m_wbsel;
   logic [2:0]  m_funct3;
   logic [31:0] m_alu_res;
   logic [31:0] m_memdata;
   logic [31:0] m_pc4;
   logic        rf_wr;
   logic [4:0]  rf_wadr;
   logic [31:0] rf_wdt;
   logic        wb_valid;
`ifdef WB_INSTRET_EN
   logic [3:0]  instret;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_wb_stage #(
      .XLEN(32),
      .CNT_W(
`ifdef WB_INSTRET_EN
         4
`else
         64
`endif
      )
   ) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .m_valid(m_valid), .m_regwrite(m_regwrite), .m_rd(m_rd),
      .m_wbsel(m_wbsel), .m_funct3(m_funct3), .m_alu_res(m_alu_res),
      .m_memdata(m_memdata), .m_pc4(m_pc4),
      .rf_wr(rf_wr), .rf_wadr(rf_wadr), .rf_wdt(rf_wdt),
`ifdef WB_INSTRET_EN
      .instret(instret),
`endif
      .wb_valid(wb_valid)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4);
      m_valid    = v;
      m_regwrite = rw;
      m_rd       = rd;
      m_wbsel    = sel;
      m_funct3   = f3;
      m_alu_res  = alu;
      m_pc4      = pc4;
   endtask

   task automatic do_load(input string tag, input logic [2:0] f3, input logic [1:0] off, input logic [31:0] exp);
      drive(1'b1, 1'b1, 5'd7, 2'b01, f3, 32'h1000_0000 | {30'd0, off}, 32'h0);
      tick();
      check(tag, {32'd0, rf_wdt}, {32'd0, exp});
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0;
      m_memdata = 32'h0;
      drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b000, 32'h0, 32'h0);
      #1;
      check("rst_rf_wr",    {63'd0, rf_wr},    64'd0);
      check("rst_rf_wadr",  {59'd0, rf_wadr},  64'd0);
      check("rst_rf_wdt",   {32'd0, rf_wdt},   64'd0);
      check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // ALU writeback
      drive(1'b1, 1'b1, 5'd5, 2'b00, 3'b010, 32'h1234_5678, 32'h0);
      tick();
      check("alu_rf_wr",    {63'd0, rf_wr},    64'd1);
      check("alu_rf_wadr",  {59'd0, rf_wadr},  64'd5);
      check("alu_rf_wdt",   {32'd0, rf_wdt},   64'h1234_5678);
      check("alu_wb_valid", {63'd0, wb_valid}, 64'd1);

      // Inputs alone must not reach outputs before the clock edge
      drive(1'b1, 1'b1, 5'd9, 2'b10, 3'b010, 32'hDEAD_BEEF, 32'h0000_0200);
      #2;
      check("comb_isolate_wdt",  {32'd0, rf_wdt},  64'h1234_5678);
      check("comb_isolate_wadr", {59'd0, rf_wadr}, 64'd5);

      // Loads
      m_memdata = 32'h80FF_7F01;
      do_load("lb_off2",  3'b000, 2'd2, 32'hFFFF_FFFF);
      do_load("lbu_off3", 3'b100, 2'd3, 32'h0000_0080);
      do_load("lh_off2",  3'b001, 2'd2, 32'hFFFF_80FF);
      do_load("lhu_off0", 3'b101, 2'd0, 32'h0000_7F01);
      do_load("lw_off1",  3'b010, 2'd1, 32'h80FF_7F01);
      do_load("lb_off0",  3'b000, 2'd0, 32'h0000_0001);
      do_load("lb_off3",  3'b000, 2'd3, 32'hFFFF_FF80);
      do_load("lh_off3",  3'b001, 2'd3, 32'hFFFF_80FF);
      do_load("lbu_off1", 3'b100, 2'd1, 32'h0000_007F);
      do_load("f3_110_w", 3'b110, 2'd2, 32'h80FF_7F01);
      check("load_rf_wr", {63'd0, rf_wr}, 64'd1);

      // rd = x0 never writes; PC+4 select
      drive(1'b1, 1'b1, 5'd0, 2'b10, 3'b010, 32'h5555_5555, 32'h0000_0104);
      tick();
      check("x0_rf_wr",    {63'd0, rf_wr},    64'd0);
      check("pc4_rf_wdt",  {32'd0, rf_wdt},   64'h0000_0104);
      check("x0_wb_valid", {63'd0, wb_valid}, 64'd1);

      // wbsel = 11 yields zero
      drive(1'b1, 1'b1, 5'd3, 2'b11, 3'b010, 32'h5555_5555, 32'h0000_0104);
      tick();
      check("zero_rf_wdt", {32'd0, rf_wdt}, 64'd0);
      check("zero_rf_wr",  {63'd0, rf_wr},  64'd1);

      // Bubble with stale nonzero fields
      drive(1'b0, 1'b1, 5'd9, 2'b00, 3'b010, 32'h0000_0099, 32'h0);
      tick();
      check("bubble_rf_wr",    {63'd0, rf_wr},    64'd0);
      check("bubble_wb_valid", {63'd0, wb_valid}, 64'd0);

      // Stall freezes the entry
      drive(1'b1, 1'b1, 5'd10, 2'b00, 3'b010, 32'h0000_AAAA, 32'h0);
      tick();
      stall = 1'b1;
      drive(1'b1, 1'b1, 5'd11, 2'b00, 3'b010, 32'h0000_BBBB, 32'h0);
      tick();
      check("stall1_wdt",  {32'd0, rf_wdt},  64'h0000_AAAA);
      check("stall1_wadr", {59'd0, rf_wadr}, 64'd10);
      drive(1'b1, 1'b1, 5'd12, 2'b10, 3'b010, 32'h0000_CCCC, 32'h0000_0300);
      tick();
      check("stall2_wdt",  {32'd0, rf_wdt},  64'h0000_AAAA);
      check("stall2_wadr", {59'd0, rf_wadr}, 64'd10);
      check("stall2_wr",   {63'd0, rf_wr},   64'd1);
      flush = 1'b1;
      tick();
      check("flush_wb_valid", {63'd0, wb_valid}, 64'd0);
      check("flush_rf_wr",    {63'd0, rf_wr},    64'd0);
      check("flush_rf_wdt",   {32'd0, rf_wdt},   64'd0);
      stall = 1'b0; flush = 1'b0;

      // Asynchronous reset mid-cycle with a valid entry held
      drive(1'b1, 1'b1, 5'd6, 2'b00, 3'b010, 32'h0000_7777, 32'h0);
      tick();
      check("pre_rst_wr", {63'd0, rf_wr}, 64'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_rf_wr",    {63'd0, rf_wr},    64'd0);
      check("arst_rf_wadr",  {59'd0, rf_wadr},  64'd0);
      check("arst_rf_wdt",   {32'd0, rf_wdt},   64'd0);
      check("arst_wb_valid", {63'd0, wb_valid}, 64'd0);
`ifdef WB_INSTRET_EN
      check("arst_instret", {60'd0, instret}, 64'd0);
`endif
      @(negedge clk);
      rst = 1'b0;

`ifdef WB_INSTRET_EN
      // 10 valid, 2 stall cycles mid-stream, 3 bubbles
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b1, 5'd1, 2'b00, 3'b010, i, 32'h0);
         tick();
         if (i == 4) begin
            stall = 1'b1;
            tick();
            tick();
            stall = 1'b0;
         end
      end
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b010, 32'h0, 32'h0);
         tick();
      end
      check("instret_10", {60'd0, instret}, 64'd10);
      // Six more retirements wrap a 4-bit counter to zero
      for (int i = 0; i < 6; i++) begin
         drive(1'b1, 1'b1, 5'd2, 2'b00, 3'b010, i, 32'h0);
         tick();
      end
      drive(1'b0, 1'b0, 5'd0, 2'b00, 3'b010, 32'h0, 32'h0);
      tick();
      check("instret_wrap", {60'd0, instret}, 64'd0);
`endif

      check("post_rst_wb_valid", {63'd0, wb_valid}, 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
